// File: rtl/mem_boot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_boot_pkg                                                    |
// | Purpose  : Shared types for the boot/run memory-port arbiter: controller   |
// |            state encoding, port-owner select and default bus widths.       |
// | Contents : MEM_ADDR_W / MEM_DATA_W  default address / data widths          |
// |            state_e                  LOAD / RUN / DBG controller states     |
// |            owner_e                  which master drives the memory port    |
// |            owner_of()               state -> port owner decode             |
// | Options  : MEM_DBG_PORT_EN (used by the files importing this package)      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mem_boot_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DBG  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_LOADER = 2'd0,
    OWN_PROC   = 2'd1,
    OWN_DBG    = 2'd2
  } owner_e;

  // Port ownership is a pure function of the registered state, so the memory
  // mux never depends on same-cycle request inputs for its select.
  function automatic owner_e owner_of(input state_e st);
    owner_e own;
    case (st)
      LOAD:    own = OWN_LOADER;
      RUN:     own = OWN_PROC;
      DBG:     own = OWN_DBG;
      default: own = OWN_LOADER;
    endcase
    return own;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_boot_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_boot_arb_if                                                 |
// | Purpose  : Bundles every non-clock/reset signal of mem_boot_arb.           |
// | Ports    : ld*       boot stream (valid/data/last in, ready out)           |
// |            cpuRst, bootDone, loadCount   boot status outputs               |
// |            proc*     processor request in, procHold out                    |
// |            dbg*      debug request in, dbgGnt out (MEM_DBG_PORT_EN only)   |
// |            mem*      write enable / address / data towards the memory      |
// | Modports : slave  - the arbiter side                                       |
// |            master - the environment (loader, proc, debug, memory)          |
// | Options  : MEM_DBG_PORT_EN adds the debug signals                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface mem_boot_arb_if
  import mem_boot_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);

  // Boot stream and status
  logic              ldValid;
  logic [DATA_W-1:0] ldData;
  logic              ldLast;
  logic              ldReady;
  logic              cpuRst;
  logic              bootDone;
  logic [ADDR_W-1:0] loadCount;

  // Processor request
  logic              procWe;
  logic [ADDR_W-1:0] procAddr;
  logic [DATA_W-1:0] procToMem;
  logic              procHold;

`ifdef MEM_DBG_PORT_EN
  // Debug request
  logic              dbgReq;
  logic              dbgWe;
  logic [ADDR_W-1:0] dbgAddr;
  logic [DATA_W-1:0] dbgData;
  logic              dbgGnt;
`endif

  // Memory port
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memIn;

  modport slave (
`ifdef MEM_DBG_PORT_EN
    input  dbgReq, dbgWe, dbgAddr, dbgData,
    output dbgGnt,
`endif
    input  ldValid, ldData, ldLast,
    output ldReady, cpuRst, bootDone, loadCount,
    input  procWe, procAddr, procToMem,
    output procHold,
    output memWe, memAddr, memIn
  );

  modport master (
`ifdef MEM_DBG_PORT_EN
    output dbgReq, dbgWe, dbgAddr, dbgData,
    input  dbgGnt,
`endif
    output ldValid, ldData, ldLast,
    input  ldReady, cpuRst, bootDone, loadCount,
    output procWe, procAddr, procToMem,
    input  procHold,
    input  memWe, memAddr, memIn
  );

endinterface
`default_nettype wire

// File: rtl/mem_boot_arb_dbg_fairness_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dbg_fairness_ctr                                                |
// | Purpose  : Counts consecutive debug-owned cycles and raises force_release  |
// |            in the DBG_MAX-th one so proc is handed one cycle of the port.  |
// | Ports    : clk, rst         clock, synchronous active-high reset          |
// |            in_dbg           debug currently owns the port                 |
// |            clr              the port leaves debug ownership on this edge  |
// |            force_release    this is the last debug cycle allowed in a row |
// | Options  : instantiated only when MEM_DBG_PORT_EN is defined               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dbg_fairness_ctr
  import mem_boot_pkg::*;
#(
  parameter int DBG_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_dbg,
  input  logic clr,
  output logic force_release
);

  // The count only ever reaches DBG_MAX-1, so clog2(DBG_MAX) bits suffice.
  localparam int CNT_W = (DBG_MAX > 1) ? $clog2(DBG_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBG_MAX - 1);

  logic [CNT_W-1:0] dbg_cnt_q;
  logic [CNT_W-1:0] dbg_cnt_d;

  always_comb begin
    dbg_cnt_d = dbg_cnt_q;
    if (clr) begin
      dbg_cnt_d = '0;
    end else if (in_dbg) begin
      dbg_cnt_d = dbg_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_cnt_q <= '0;
    end else begin
      dbg_cnt_q <= dbg_cnt_d;
    end
  end

  assign force_release = in_dbg && (dbg_cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_boot_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_boot_arb                                                    |
// | Purpose  : Owns the single memory port: loads a boot stream from address  |
// |            0 while proc is held in reset, then gives the port to proc and |
// |            optionally time-shares it with a debug requester.              |
// | Ports    : clk   single clock, rising edge                                |
// |            rst   synchronous active-high reset                            |
// |            bus   mem_boot_arb_if.slave (boot stream, status, proc, debug, |
// |                  memory write/address/data)                               |
// | Params   : ADDR_W, DATA_W  bus widths                                     |
// |            DEPTH           loadable words, last load address DEPTH-1      |
// |            DBG_MAX         max consecutive debug cycles                   |
// | Options  : MEM_DBG_PORT_EN enables the debug port, DBG state and fairness |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mem_boot_arb
  import mem_boot_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int DEPTH   = 1024,
  parameter int DBG_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_boot_arb_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] load_ptr_q;
  logic [ADDR_W-1:0] load_ptr_d;
  owner_e            owner;

`ifdef MEM_DBG_PORT_EN
  logic force_release;
  logic dbg_clr;

  // Clearing whenever the next state is not DBG resets the run length on
  // every return to RUN, forced or voluntary.
  assign dbg_clr = (state_d != DBG);

  dbg_fairness_ctr #(
    .DBG_MAX (DBG_MAX)
  ) u_dbg_fairness_ctr (
    .clk           (clk),
    .rst           (rst),
    .in_dbg        (state_q == DBG),
    .clr           (dbg_clr),
    .force_release (force_release)
  );
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    case (state_q)
      LOAD: begin
        // ldReady is constantly high in LOAD, so ldValid alone accepts a word;
        // ldLast is only meaningful alongside it.
        if (bus.ldValid) begin
          load_ptr_d = load_ptr_q + ADDR_W'(1);
          if (bus.ldLast || (load_ptr_q == LAST_ADDR)) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
`ifdef MEM_DBG_PORT_EN
        // proc keeps the port in the cycle the request is first seen. After a
        // forced release this RUN cycle is proc's guaranteed slot.
        if (bus.dbgReq) begin
          state_d = DBG;
        end
`else
        state_d = RUN;
`endif
      end
      DBG: begin
`ifdef MEM_DBG_PORT_EN
        if (!bus.dbgReq || force_release) begin
          state_d = RUN;
        end
`else
        state_d = RUN;
`endif
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      load_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory port mux. rst gates every output so an in-flight write is dropped
  // in the reset cycle and the outputs show their reset values even before
  // the first clock edge has initialised the state register.
  // ---------------------------------------------------------------------------
  assign owner = owner_of(state_q);

  always_comb begin
    bus.memWe   = 1'b0;
    bus.memAddr = '0;
    bus.memIn   = '0;
    if (!rst) begin
      case (owner)
        OWN_LOADER: begin
          bus.memWe   = bus.ldValid;
          bus.memAddr = load_ptr_q;
          bus.memIn   = bus.ldData;
        end
        OWN_PROC: begin
          bus.memWe   = bus.procWe;
          bus.memAddr = bus.procAddr;
          bus.memIn   = bus.procToMem;
        end
`ifdef MEM_DBG_PORT_EN
        OWN_DBG: begin
          bus.memWe   = bus.dbgWe;
          bus.memAddr = bus.dbgAddr;
          bus.memIn   = bus.dbgData;
        end
`endif
        default: begin
          bus.memWe   = 1'b0;
          bus.memAddr = '0;
          bus.memIn   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign bus.ldReady   = !rst && (state_q == LOAD);
  assign bus.cpuRst    = rst  || (state_q == LOAD);
  // Only rst returns the state to LOAD, so "not LOAD" is sticky until rst.
  assign bus.bootDone  = !rst && (state_q != LOAD);
  assign bus.loadCount = rst ? '0 : load_ptr_q;

`ifdef MEM_DBG_PORT_EN
  assign bus.dbgGnt    = !rst && (state_q == DBG);
  assign bus.procHold  = !rst && (state_q == DBG);
`else
  assign bus.procHold  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_boot_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_boot_arb                                                 |
// | Purpose  : Self-checking bench for mem_boot_arb: a per-cycle vector table  |
// |            for boot/reset behaviour, plus sequences for full-depth boot,  |
// |            a stalled stream and (MEM_DBG_PORT_EN) debug/fairness.         |
// | Options  : MEM_DBG_PORT_EN enables the debug sequences                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_boot_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_boot_arb_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_boot_arb #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .DEPTH   (1024),
    .DBG_MAX (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural memory on the arbiter's port.
  logic [15:0] tb_mem [0:65535];
  always @(posedge clk) begin
    if (bus.memWe === 1'b1) tb_mem[bus.memAddr] <= bus.memIn;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive_idle();
    bus.ldValid   = 1'b0;
    bus.ldData    = '0;
    bus.ldLast    = 1'b0;
    bus.procWe    = 1'b0;
    bus.procAddr  = '0;
    bus.procToMem = '0;
`ifdef MEM_DBG_PORT_EN
    bus.dbgReq  = 1'b0;
    bus.dbgWe   = 1'b0;
    bus.dbgAddr = '0;
    bus.dbgData = '0;
`endif
  endtask

  // One row per cycle: inputs driven after negedge, outputs checked 2 ns later;
  // the memory check reflects writes from the edges before this row.
  typedef struct {
    logic        rst, v, last;
    logic [15:0] ld_data;
    logic        pwe;
    logic [15:0] paddr, pdata;
    logic        e_ready, e_crst, e_done, e_we;
    logic [15:0] e_addr, e_in, e_cnt;
    logic        mchk;
    logic [15:0] maddr, mval;
  } vec_t;

  vec_t vecs [17];

  initial begin
    for (int i = 0; i < 65536; i++) tb_mem[i] = 16'h0000;
    rst = 1'b1;
    drive_idle();

    //             rst v last data      pwe paddr    pdata     rdy crst done we addr     in        cnt      mchk maddr    mval
    vecs[0]  = '{1'b1,1'b1,1'b0,16'h1234, 1'b0,16'h0000,16'h0000, 1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000,16'h0000, 1'b0,16'h0000,16'h0000};
    vecs[1]  = '{1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'h0000, 1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000,16'h0000, 1'b0,16'h0000,16'h0000};
    vecs[2]  = '{1'b0,1'b1,1'b0,16'h1111, 1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b0,1'b1,16'h0000,16'h1111,16'h0000, 1'b0,16'h0000,16'h0000};
    vecs[3]  = '{1'b0,1'b0,1'b1,16'h0000, 1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b0,1'b0,16'h0001,16'h0000,16'h0001, 1'b1,16'h0000,16'h1111};
    vecs[4]  = '{1'b0,1'b1,1'b0,16'h2222, 1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b0,1'b1,16'h0001,16'h2222,16'h0001, 1'b0,16'h0000,16'h0000};
    vecs[5]  = '{1'b0,1'b1,1'b1,16'h3333, 1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b0,1'b1,16'h0002,16'h3333,16'h0002, 1'b1,16'h0001,16'h2222};
    vecs[6]  = '{1'b0,1'b1,1'b0,16'h9999, 1'b1,16'h0040,16'h5A5A, 1'b0,1'b0,1'b1,1'b1,16'h0040,16'h5A5A,16'h0003, 1'b1,16'h0002,16'h3333};
    vecs[7]  = '{1'b0,1'b0,1'b0,16'h0000, 1'b0,16'hFFFF,16'h0000, 1'b0,1'b0,1'b1,1'b0,16'hFFFF,16'h0000,16'h0003, 1'b1,16'h0040,16'h5A5A};
    vecs[8]  = '{1'b1,1'b1,1'b0,16'h8888, 1'b1,16'h0000,16'h7777, 1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000,16'h0000, 1'b0,16'h0000,16'h0000};
    vecs[9]  = '{1'b0,1'b1,1'b0,16'h0101, 1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b0,1'b1,16'h0000,16'h0101,16'h0000, 1'b1,16'h0000,16'h1111};
    vecs[10] = '{1'b0,1'b1,1'b0,16'h0202, 1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b0,1'b1,16'h0001,16'h0202,16'h0001, 1'b1,16'h0000,16'h0101};
    vecs[11] = '{1'b0,1'b1,1'b0,16'h0303, 1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b0,1'b1,16'h0002,16'h0303,16'h0002, 1'b0,16'h0000,16'h0000};
    vecs[12] = '{1'b0,1'b1,1'b0,16'h0404, 1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b0,1'b1,16'h0003,16'h0404,16'h0003, 1'b0,16'h0000,16'h0000};
    vecs[13] = '{1'b0,1'b1,1'b0,16'h0505, 1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b0,1'b1,16'h0004,16'h0505,16'h0004, 1'b0,16'h0000,16'h0000};
    vecs[14] = '{1'b1,1'b1,1'b0,16'h0606, 1'b0,16'h0000,16'h0000, 1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000,16'h0000, 1'b1,16'h0004,16'h0505};
    vecs[15] = '{1'b0,1'b1,1'b1,16'hAAAA, 1'b0,16'h0000,16'h0000, 1'b1,1'b1,1'b0,1'b1,16'h0000,16'hAAAA,16'h0000, 1'b0,16'h0000,16'h0000};
    vecs[16] = '{1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0123,16'h0456, 1'b0,1'b0,1'b1,1'b0,16'h0123,16'h0456,16'h0001, 1'b1,16'h0000,16'hAAAA};

    @(negedge clk);

    // ---------------- table: basic boot, proc pass-through, reset mid-load
    for (int r = 0; r < 17; r++) begin
      rst           = vecs[r].rst;
      bus.ldValid   = vecs[r].v;
      bus.ldLast    = vecs[r].last;
      bus.ldData    = vecs[r].ld_data;
      bus.procWe    = vecs[r].pwe;
      bus.procAddr  = vecs[r].paddr;
      bus.procToMem = vecs[r].pdata;
      #2;
      check($sformatf("row%0d ldReady", r),   32'(bus.ldReady),   32'(vecs[r].e_ready));
      check($sformatf("row%0d cpuRst", r),    32'(bus.cpuRst),    32'(vecs[r].e_crst));
      check($sformatf("row%0d bootDone", r),  32'(bus.bootDone),  32'(vecs[r].e_done));
      check($sformatf("row%0d memWe", r),     32'(bus.memWe),     32'(vecs[r].e_we));
      check($sformatf("row%0d memAddr", r),   32'(bus.memAddr),   32'(vecs[r].e_addr));
      check($sformatf("row%0d memIn", r),     32'(bus.memIn),     32'(vecs[r].e_in));
      check($sformatf("row%0d loadCount", r), 32'(bus.loadCount), 32'(vecs[r].e_cnt));
      check($sformatf("row%0d procHold", r),  32'(bus.procHold),  32'(0));
      if (vecs[r].mchk)
        check($sformatf("row%0d mem[%h]", r, vecs[r].maddr), 32'(tb_mem[vecs[r].maddr]), 32'(vecs[r].mval));
      @(negedge clk);
    end

    // ---------------- full-depth boot: 1024 words, no ldLast
    begin
      logic full_ok;
      full_ok = 1'b1;
      drive_idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 1024; i++) begin
        bus.ldValid = 1'b1;
        bus.ldData  = 16'(i);
        #2;
        if (!(bus.memWe === 1'b1 && bus.memAddr === 16'(i) && bus.ldReady === 1'b1 && bus.cpuRst === 1'b1))
          full_ok = 1'b0;
        @(negedge clk);
      end
      check("full contiguous writes", 32'(full_ok), 32'(1));
      bus.ldData = 16'hDEAD;      // 1025th word, must be ignored
      #2;
      check("full ldReady after",   32'(bus.ldReady),   32'(0));
      check("full loadCount",       32'(bus.loadCount), 32'(1024));
      check("full 1025th memWe",    32'(bus.memWe),     32'(0));
      check("full cpuRst released", 32'(bus.cpuRst),    32'(0));
      @(negedge clk);
      drive_idle();
      #2;
      check("full mem[1023]", 32'(tb_mem[1023]), 32'(16'h03FF));
      check("full mem[0]",    32'(tb_mem[0]),    32'(16'h0000));
      check("full mem[1024]", 32'(tb_mem[1024]), 32'(16'h0000));
      @(negedge clk);
    end

    // ---------------- stalled stream: 3-cycle ldValid gaps
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < 4; w++) begin
      bus.ldValid = 1'b1;
      bus.ldData  = 16'h5000 + 16'(w);
      bus.ldLast  = (w == 3);
      #2;
      check($sformatf("stall word%0d memWe", w),   32'(bus.memWe),   32'(1));
      check($sformatf("stall word%0d memAddr", w), 32'(bus.memAddr), 32'(w));
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        bus.ldValid = 1'b0;
        bus.ldLast  = 1'b0;
        bus.ldData  = 16'hEEEE;
        #2;
        check($sformatf("stall gap%0d.%0d memWe", w, g), 32'(bus.memWe), 32'(0));
        @(negedge clk);
      end
    end
    for (int w = 0; w < 4; w++)
      check($sformatf("stall mem[%0d]", w), 32'(tb_mem[w]), 32'(16'h5000 + 16'(w)));
    check("stall bootDone", 32'(bus.bootDone), 32'(1));
    drive_idle();

`ifdef MEM_DBG_PORT_EN
    // ---------------- debug access: dbgReq for 3 cycles, write 0xBEEF @ 0x10
    bus.procAddr = 16'h0020;
    for (int c = 0; c < 5; c++) begin
      bus.dbgReq  = (c < 3);
      bus.dbgWe   = (c < 3);
      bus.dbgAddr = 16'h0010;
      bus.dbgData = 16'hBEEF;
      #2;
      check($sformatf("dbg c%0d dbgGnt", c),   32'(bus.dbgGnt),   32'((c >= 1 && c <= 3) ? 1 : 0));
      check($sformatf("dbg c%0d procHold", c), 32'(bus.procHold), 32'((c >= 1 && c <= 3) ? 1 : 0));
      check($sformatf("dbg c%0d memAddr", c),  32'(bus.memAddr),
            32'((c >= 1 && c <= 3) ? 16'h0010 : 16'h0020));
      @(negedge clk);
    end
    check("dbg mem[0x10]", 32'(tb_mem[16'h0010]), 32'(16'hBEEF));

    // ---------------- fairness: dbgReq for 20 cycles, DBG_MAX = 8
    // Cycle 0 is the RUN cycle that sees the request, 1..8 are granted,
    // 9 is proc's forced slot, 10..17 granted, 18 forced, 19 granted.
    for (int k = 0; k < 20; k++) begin
      bus.dbgReq    = 1'b1;
      bus.dbgWe     = 1'b0;
      bus.dbgAddr   = 16'h0200;
      bus.procWe    = 1'b1;
      bus.procAddr  = 16'h0100 + 16'(k);
      bus.procToMem = 16'hC000 + 16'(k);
      #2;
      check($sformatf("fair k%0d dbgGnt", k),   32'(bus.dbgGnt),   32'((k % 9 == 0) ? 0 : 1));
      check($sformatf("fair k%0d procHold", k), 32'(bus.procHold), 32'((k % 9 == 0) ? 0 : 1));
      @(negedge clk);
    end
    drive_idle();
    #2;
    check("fair release lag dbgGnt", 32'(bus.dbgGnt), 32'(1));
    @(negedge clk);
    #2;
    check("fair after dbgGnt", 32'(bus.dbgGnt), 32'(0));
    check("fair mem[0x109]", 32'(tb_mem[16'h0109]), 32'(16'hC009));
    check("fair mem[0x112]", 32'(tb_mem[16'h0112]), 32'(16'hC012));
    check("fair mem[0x105]", 32'(tb_mem[16'h0105]), 32'(16'h0000));
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
